// File: rtl/matrix_mac_if.sv
// rtl/matrix_mac_if.sv - handshake/bus bundle for the 2x2 matrix MAC controller
interface matrix_mac_if #(
  parameter int EW = 4
) ();
  logic            in_valid;
  logic [4*EW-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [4*EW-1:0] out_trans;
  logic [4*EW-1:0] out_res;
  logic            busy;
  logic [7:0]      done_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_trans, out_res, busy, done_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_trans, out_res, busy, done_cnt
  );
endinterface

// File: rtl/matrix_mac_ctrl.sv
// rtl/matrix_mac_ctrl.sv - computes transpose(A) and A x transpose(A) with one shared multiplier
module matrix_mac_ctrl #(
  parameter int EW = 4
) (
  input logic          clk,
  input logic          rst,
  matrix_mac_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state, state_nx;
  logic [1:0][1:0][EW-1:0]   a_m;
  logic [1:0][1:0][EW-1:0]   res_m;
  logic [EW-1:0]             acc;
  logic [2:0]                step;
  logic [4*EW-1:0]           trans_q;
  logic [7:0]                done_q;
  logic                      in_ready_c;
  logic                      out_valid_c;

  // step counter decodes the element being built: res[i][j] += A[i][k]*A[j][k]
  logic          idx_i, idx_j, idx_k;
  logic [EW-1:0] mul_a, mul_b;
  logic [2*EW-1:0] prod;
  logic [EW-1:0] sum;

  assign idx_i = step[2];
  assign idx_j = step[1];
  assign idx_k = step[0];
  assign mul_a = a_m[idx_i][idx_k];
  assign mul_b = a_m[idx_j][idx_k];
  assign prod  = {{EW{1'b0}}, mul_a} * {{EW{1'b0}}, mul_b};
  assign sum   = acc + prod[EW-1:0];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state and handshake outputs; handshake-out edge returns to IDLE only, never accepts
  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = CALC;
      end
      CALC: begin
        if (step == 3'd7) state_nx = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath: capture on accept, one MAC per CALC cycle, count output handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_m     <= '0;
      res_m   <= '0;
      acc     <= '0;
      step    <= '0;
      trans_q <= '0;
      done_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_m[0][0] <= bus.in_data[4*EW-1 -: EW];
            a_m[0][1] <= bus.in_data[3*EW-1 -: EW];
            a_m[1][0] <= bus.in_data[2*EW-1 -: EW];
            a_m[1][1] <= bus.in_data[EW-1:0];
            trans_q   <= {bus.in_data[4*EW-1 -: EW], bus.in_data[2*EW-1 -: EW],
                          bus.in_data[3*EW-1 -: EW], bus.in_data[EW-1:0]};
            res_m     <= '0;
            acc       <= '0;
            step      <= '0;
          end
        end
        CALC: begin
          if (idx_k) begin
            res_m[idx_i][idx_j] <= sum;
            acc                 <= '0;
          end else begin
            acc <= sum;
          end
          step <= step + 3'd1;
        end
        DONE: begin
          if (bus.out_ready) done_q <= done_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = ~in_ready_c;
  assign bus.out_trans = trans_q;
  assign bus.out_res   = {res_m[0][0], res_m[0][1], res_m[1][0], res_m[1][1]};
  assign bus.done_cnt  = done_q;

endmodule

// File: tb/tb_matrix_mac_ctrl.sv
// tb/tb_matrix_mac_ctrl.sv - self-checking bench for matrix_mac_ctrl
module tb_matrix_mac_ctrl;
  localparam int EW = 4;

  typedef struct {
    logic [15:0] din;
    logic [15:0] trans;
    logic [15:0] res;
  } vec_t;

  typedef struct {
    logic [15:0] trans;
    logic [15:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_acc = 0;
  bit   have_last = 0;
  bit   b2b = 0;
  exp_t sb[$];
  vec_t vecs[5];

  matrix_mac_if #(.EW(EW)) bus ();

  matrix_mac_ctrl #(.EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic exp_t model(input logic [15:0] d);
    int   m[2][2];
    int   r[2][2];
    exp_t e;
    m[0][0] = int'(d[15:12]);
    m[0][1] = int'(d[11:8]);
    m[1][0] = int'(d[7:4]);
    m[1][1] = int'(d[3:0]);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[i][j] = (m[i][0] * m[j][0] + m[i][1] * m[j][1]) % 16;
    e.res   = {4'(r[0][0]), 4'(r[0][1]), 4'(r[1][0]), 4'(r[1][1])};
    e.trans = {d[15:12], d[7:4], d[11:8], d[3:0]};
    return e;
  endfunction

  // scoreboard: push on input handshake, pop and compare on output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_data));
        if (b2b && have_last) chk("accept_interval", 16'(cyc - last_acc), 16'd10);
        last_acc  = cyc;
        have_last = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 16'd0, 16'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_trans", bus.out_trans, e.trans);
          chk("sb_res", bus.out_res, e.res);
        end
      end
    end
  end

  initial begin
    int n;
    int g;
    logic [7:0] exp_done;
    logic [15:0] hold_t, hold_r;

    vecs[0] = '{16'h1001, 16'h1001, 16'h1001};
    vecs[1] = '{16'h1234, 16'h1324, 16'h5BB9};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h2222};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{16'h8421, 16'h8241, 16'h0445};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    exp_done      = 8'd0;

    #3;
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_done_cnt", {8'd0, bus.done_cnt}, 16'd0);
    chk("rst_trans", bus.out_trans, 16'h0000);
    chk("rst_res", bus.out_res, 16'h0000);
    tick();
    rst = 1'b0;

    // table vectors with out_ready held high
    bus.out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      chk("idle_ready", {15'd0, bus.in_ready}, 16'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[v].din;
      tick();
      bus.in_valid = 1'b0;
      chk("busy_calc", {15'd0, bus.busy}, 16'd1);
      n = 1;
      while (!bus.out_valid && n < 40) begin
        tick();
        n++;
      end
      chk("latency", 16'(n), 16'd9);
      chk("vec_trans", bus.out_trans, vecs[v].trans);
      chk("vec_res", bus.out_res, vecs[v].res);
      tick();
      exp_done++;
      chk("post_in_ready", {15'd0, bus.in_ready}, 16'd1);
      chk("vec_done_cnt", {8'd0, bus.done_cnt}, {8'd0, exp_done});
    end

    // DONE stall with input noise
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("stall_reach_done", {15'd0, bus.out_valid}, 16'd1);
    hold_t = bus.out_trans;
    hold_r = bus.out_res;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 16'($urandom);
      tick();
      chk("stall_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("stall_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("stall_trans", bus.out_trans, 16'h1324);
      chk("stall_res", bus.out_res, 16'h5BB9);
      chk("stall_stable", bus.out_res ^ hold_r ^ bus.out_trans ^ hold_t, 16'h0000);
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hFFFF;
    bus.out_ready = 1'b1;
    tick();
    exp_done++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stall_release_idle", {15'd0, bus.in_ready}, 16'd1);
    chk("stall_done_cnt", {8'd0, bus.done_cnt}, {8'd0, exp_done});
    chk("stall_no_accept", 16'(sb.size()), 16'd0);

    // asynchronous reset during CALC step 4
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("arst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("arst_done_cnt", {8'd0, bus.done_cnt}, 16'd0);
    chk("arst_res", bus.out_res, 16'h0000);
    sb.delete();
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("arst_first_accept", {15'd0, bus.busy}, 16'd1);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("arst_latency", 16'(n), 16'd9);
    chk("arst_res_after", bus.out_res, 16'h5BB9);
    tick();
    chk("arst_done_after", {8'd0, bus.done_cnt}, 16'd1);

    // 256 back-to-back transactions from a fresh reset
    rst = 1'b1;
    tick();
    sb.delete();
    rst = 1'b0;
    chk("b2b_start_cnt", {8'd0, bus.done_cnt}, 16'd0);
    n_out     = 0;
    have_last = 0;
    b2b       = 1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    g = 0;
    while (n_out < 256 && g < 3500) begin
      bus.in_data = 16'($urandom);
      tick();
      g++;
    end
    bus.in_valid = 1'b0;
    b2b = 0;
    chk("b2b_count", 16'(n_out), 16'd256);
    chk("b2b_wrap", {8'd0, bus.done_cnt}, 16'd0);
    tick();
    chk("b2b_sb_empty", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_mac_ctrl.md
MATRIX_MAC_CTRL -- requirements
Module: matrix_mac_ctrl

Interface
REQ-001 The block SHALL have parameter EW, default 4, meaning the element width in bits; a packed matrix SHALL be 4*EW bits wide, ordered {m00,m01,m10,m11} with m00 in the MSBs.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid matrix A.
REQ-005 The block SHALL have port in_data, input, 4*EW bits: the packed input matrix A.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a matrix.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_trans and out_res hold a valid result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-009 The block SHALL have port out_trans, output, 4*EW bits: the packed transpose of A.
REQ-010 The block SHALL have port out_res, output, 4*EW bits: the packed product A x transpose(A).
REQ-011 The block SHALL have port busy, output, 1 bit: the block is in state CALC or DONE.
REQ-012 The block SHALL have port done_cnt, output, 8 bits: the count of completed output handshakes.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, out_valid SHALL be 1 only in DONE, and busy SHALL equal NOT in_ready.
REQ-014 In IDLE, when in_valid=1 on a clock edge, the block SHALL register in_data into internal matrix A, clear all result elements and the accumulator, set the step counter to 0 and go to CALC.
REQ-015 In IDLE with in_valid=0, the block SHALL hold all state.
REQ-016 CALC SHALL last exactly 8 cycles with step counter s=0..7, decoded as i=s[2], j=s[1], k=s[0].
REQ-017 Each CALC cycle SHALL add one product A[i][k]*A[j][k] to the accumulator, using a single shared EW x EW multiplier.
REQ-018 When k=1, the block SHALL write the completed sum to res[i][j] and clear the accumulator.
REQ-019 All sums SHALL be truncated to EW bits, which is modulo 2^EW, with no saturation and no overflow flag.
REQ-020 out_trans SHALL be registered at acceptance as {m00,m10,m01,m11}, so that trans[j][i] = A[i][j].
REQ-021 At s=7 the block SHALL go to DONE; out_valid SHALL therefore first be 1 after the 9th rising edge counting the acceptance edge as the 1st.
REQ-022 In DONE, out_trans and out_res SHALL remain stable while out_ready=0, for any number of cycles.
REQ-023 While busy=1, in_valid and in_data SHALL be ignored.
REQ-024 In DONE, when out_ready=1 on a clock edge, the block SHALL go to IDLE and increment done_cnt, wrapping from 255 to 0.
REQ-025 A new matrix SHALL NOT be accepted on the same edge as an output handshake; the minimum accept-to-accept interval SHALL be 10 cycles.
REQ-026 out_ready while not in DONE SHALL have no effect.
REQ-027 out_trans and out_res SHALL retain their last values in IDLE; only out_valid qualifies them.

Reset
REQ-028 While rst=1, the FSM SHALL be IDLE; in_ready SHALL be 1; out_valid and busy SHALL be 0; out_trans, out_res, the accumulator, the step counter and done_cnt SHALL be 0.
REQ-029 Assertion of rst SHALL take effect immediately, without waiting for a clock edge, including mid-CALC or in DONE; any in-progress result SHALL be discarded and done_cnt SHALL NOT increment.
REQ-030 After rst deasserts, the block SHALL accept in_valid on the first rising edge.

Verification
REQ-031 in_data=16'h1001 (identity), out_ready=1 -> out_trans=16'h1001, out_res=16'h1001, out_valid high on edge 9, done_cnt=1.
REQ-032 in_data=16'h1234 -> out_trans=16'h1324, out_res=16'h5BB9 (25 mod 16 = 9).
REQ-033 in_data=16'hFFFF -> out_trans=16'hFFFF, out_res=16'h2222 (450 mod 16 = 2, truncation check).
REQ-034 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and in_data -> outputs stable, in_ready=0, no new accept; then out_ready=1 -> IDLE next cycle, done_cnt increments.
REQ-035 Assert rst at CALC step 4 -> out_valid=0 and in_ready=1 immediately, done_cnt=0; a following accept of 16'h1234 -> out_res=16'h5BB9.
REQ-036 Run 256 back-to-back transactions -> done_cnt wraps to 0; accept-to-accept interval measured as exactly 10 cycles.
